ysyx_23060061_isram_responder: RTL and testbench
================================================

Name: ysyx_23060061_isram_responder

Overview:
Memory-side responder for the instruction-fetch read path. The IFU issues one word-aligned read request per handshake. This block answers each accepted request after a fixed, parameterised latency, returning data from an internal word array plus a response code. A separate synchronous load port preloads the program image.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, word width
DEPTH, 1024, number of words in the array (power of two)
BASE, 32'h8000_0000, byte address of word 0
LATENCY, 2, extra wait cycles between acceptance and response (0..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
arvalid  in  1  read request valid
arready  out  1  responder can accept a request
araddr  in  ADDR_W  byte address of requested word
rvalid  out  1  response valid
rready  in  1  requester accepts the response
rdata  out  DATA_W  returned word
rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
ld_en  in  1  preload write enable
ld_addr  in  ADDR_W  preload byte address
ld_data  in  DATA_W  preload word

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, counter=0.
  - rvalid=0, rdata=0, rresp=2'b00.
  - arready=1 (combinational, = state==IDLE).
  - Array contents are not reset.
- States:
  - IDLE: arready=1. On arvalid&arready: latch araddr, load counter=LATENCY, go to WAIT if LATENCY>0, else RESP.
  - WAIT: arready=0. Counter decrements each cycle; when counter==1, go to RESP on the next edge.
  - RESP: rvalid=1, rdata/rresp held stable. On rvalid&rready, go to IDLE.
- Timing: acceptance edge T, first rvalid=1 in cycle T+1+LATENCY. Minimum turnaround is 2 cycles per request when rready is tied high.
- No new request is accepted until the current response completes (single outstanding). arready is low from the cycle after acceptance until the cycle after the response handshake.
- Address check, evaluated on the latched address:
  - Error if misaligned (addr[1:0]!=0), addr<BASE, or addr>=BASE+4*DEPTH.
  - Error: rresp=2'b10, rdata=0.
  - Otherwise: rresp=2'b00, rdata=array[(addr-BASE)>>2] with log2(DEPTH) index bits.
  - Subtraction is ADDR_W-bit unsigned; no wrap above the upper bound.
- rdata/rresp are registered on the edge that enters RESP. They hold while rvalid=1 and rready=0 (backpressure, unbounded). After the handshake they keep their last values, don't-care.
- Load port: synchronous write on the edge where ld_en=1 and ld_addr is an in-range, aligned address; otherwise the write is ignored. It is legal in any state.
- Collision: if a load write and the RESP-entering read sample target the same word on the same edge, the read returns the old word. A write on any earlier edge is visible.
- rst asserted mid-WAIT or mid-RESP: response is dropped immediately (rvalid=0), state=IDLE, no response is owed after release.
- arvalid while rst=1 is ignored.

Decomposition:
- Shared package ysyx_23060061_mem_pkg:
  - response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - state encoding IDLE/WAIT/RESP
  - default BASE constant
- One sub-module: ysyx_23060061_sram_array. It holds the DEPTH x DATA_W storage with one synchronous write port and one synchronous read port, read-before-write on the same address.
- The FSM, counter and range check stay in the top.

Test Plan:
- Reset/idle: assert rst mid-cycle, then release -> immediately rvalid=0, rdata=0, rresp=0, arready=1.
- Basic read, LATENCY=2: load 0x80000004<=0xDEADBEEF; request 0x80000004 accepted at edge T, rready=1 -> rvalid high exactly in cycle T+3, rdata=0xDEADBEEF, rresp=0, arready returns to 1 the cycle after the handshake.
- Backpressure: same read with rready=0 for 5 cycles -> rvalid stays 1, rdata/rresp stable, arready=0 throughout; rready=1 -> handshake completes, next request accepted one cycle later.
- Errors: requests to 0x7FFFFFFC, 0x80001000 (DEPTH=1024) and 0x80000002 -> each gives rresp=2'b10, rdata=0 after normal latency; array unaffected.
- Collision and back-to-back, LATENCY=0: word 0x80000010=0x11111111; write 0x22222222 on the RESP-entering edge -> response returns 0x11111111; an immediate second request to the same word returns 0x22222222. Two back-to-back requests with rready=1 complete every 2 cycles.
- Reset mid-operation: assert rst during WAIT -> rvalid stays 0, no response appears after release; a fresh request to 0x80000004 then completes normally.

Source files
------------

// File: rtl/ysyx_23060061_mem_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060061_mem_pkg
// Shared definitions for the instruction-SRAM responder:
//   - read response codes returned on rresp
//   - responder FSM state encoding
//   - default byte address of word 0 of the instruction array
// ----------------------------------------------------------------------------
package ysyx_23060061_mem_pkg;

  // Response codes on the read-response channel.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte address that maps onto word 0 of the array.
  localparam logic [31:0] DEFAULT_BASE = 32'h8000_0000;

  // Responder states.
  //   IDLE : ready for a request
  //   WAIT : request latched, burning the configured latency
  //   RESP : response presented, waiting for the requester to take it
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/ysyx_23060061_sram_array.sv
// ----------------------------------------------------------------------------
// ysyx_23060061_sram_array
// DEPTH x DATA_W word storage with one synchronous write port and one
// synchronous read port. The read data register only updates when re_i is
// high, so it holds the last word read indefinitely. When both ports hit the
// same word on the same edge the read returns the word as it was before the
// write (read-before-write).
//
// Ports:
//   clk      in   clock, rising edge
//   we_i     in   write enable
//   waddr_i  in   write word index
//   wdata_i  in   write data
//   re_i     in   read enable (captures mem[raddr_i] into rdata_o)
//   raddr_i  in   read word index
//   rdata_o  out  registered read data
// ----------------------------------------------------------------------------
module ysyx_23060061_sram_array #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 1024,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Both ports live in one clocked block: the read samples mem_q before the
  // non-blocking write lands, which gives read-before-write on a collision.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_23060061_isram_responder.sv
// ----------------------------------------------------------------------------
// ysyx_23060061_isram_responder
// Memory-side responder for the instruction-fetch read path. Accepts one
// word-aligned read request at a time, waits LATENCY cycles, then presents
// the word (or an error) until the requester takes it. A separate load port
// preloads the program image.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   arvalid  in   read request valid
//   arready  out  responder can accept a request (high only in IDLE)
//   araddr   in   byte address of requested word
//   rvalid   out  response valid
//   rready   in   requester accepts the response
//   rdata    out  returned word (0 on error)
//   rresp    out  RESP_OKAY / RESP_SLVERR
//   ld_en    in   preload write enable
//   ld_addr  in   preload byte address
//   ld_data  in   preload word
//
// Timing: a request accepted on edge T is presented from the cycle that
// follows T + LATENCY further edges. rdata/rresp are captured on the edge
// that enters RESP and hold until the next response.
// ----------------------------------------------------------------------------
module ysyx_23060061_isram_responder
  import ysyx_23060061_mem_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 32,
  parameter int                DEPTH   = 1024,
  parameter logic [ADDR_W-1:0] BASE    = ADDR_W'(DEFAULT_BASE),
  parameter int                LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int               IDX_W   = $clog2(DEPTH);
  localparam int               CNT_W   = 4;
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

  // --------------------------------------------------------------------------
  // Address decode helpers
  // --------------------------------------------------------------------------
  // An address is usable when it is word aligned and falls inside
  // [BASE, BASE + 4*DEPTH). The offset is an ADDR_W-bit unsigned difference;
  // the explicit a >= BASE term rejects addresses that would wrap around.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE;
    return (a[1:0] == 2'b00) && (a >= BASE) && ((off >> 2) < ADDR_W'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE;
    return IDX_W'(off >> 2);
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rvalid_q;
  logic [1:0]        rresp_q;
  logic              ok_q;      // current response carries array data

  // --------------------------------------------------------------------------
  // Read-side decode
  // --------------------------------------------------------------------------
  // With LATENCY == 0 the RESP-entering edge is the acceptance edge, so the
  // address has not been latched yet and araddr is used directly.
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ok;
  logic [IDX_W-1:0]  rd_idx;
  logic              enter_resp;

  assign rd_addr = (state_q == IDLE) ? araddr : addr_q;
  assign rd_ok   = addr_ok(rd_addr);
  assign rd_idx  = word_idx(rd_addr);

  assign enter_resp = ((state_q == IDLE) && arvalid && (LATENCY == 0)) ||
                      ((state_q == WAIT) && (cnt_q == CNT_W'(1)));

  // --------------------------------------------------------------------------
  // Load-side decode: misaligned or out-of-range preloads are dropped.
  // --------------------------------------------------------------------------
  logic             ld_ok;
  logic [IDX_W-1:0] ld_idx;

  assign ld_ok  = ld_en && addr_ok(ld_addr);
  assign ld_idx = word_idx(ld_addr);

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] arr_rdata;

  // The array is only read for in-range requests, so an error response never
  // disturbs the last captured word; rdata is forced to zero via ok_q instead.
  ysyx_23060061_sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_sram_array (
    .clk     (clk),
    .we_i    (ld_ok),
    .waddr_i (ld_idx),
    .wdata_i (ld_data),
    .re_i    (enter_resp && rd_ok),
    .raddr_i (rd_idx),
    .rdata_o (arr_rdata)
  );

  // --------------------------------------------------------------------------
  // Responder FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      ok_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // arready is high throughout IDLE, so arvalid alone is a handshake.
          if (arvalid) begin
            addr_q  <= araddr;
            cnt_q   <= LAT_CNT;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
        RESP: begin
          if (rready) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      // Entering RESP overrides the per-state updates above; this covers both
      // the end of WAIT and the zero-latency path straight out of IDLE.
      if (enter_resp) begin
        state_q  <= RESP;
        cnt_q    <= '0;
        rvalid_q <= 1'b1;
        rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        ok_q     <= rd_ok;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign arready = (state_q == IDLE);
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = ok_q ? arr_rdata : '0;

endmodule

// File: tb/tb_ysyx_23060061_isram_responder.sv
// ----------------------------------------------------------------------------
// Bench for ysyx_23060061_isram_responder. Two instances share clock and
// reset: instance 0 uses LATENCY=2, instance 1 uses LATENCY=0. Expected
// responses come from a word-addressed associative-array model of memory and
// a plain arithmetic range check.
// ----------------------------------------------------------------------------
module tb_ysyx_23060061_isram_responder;

  localparam int              DEPTH = 1024;
  localparam longint unsigned LBASE = 64'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        arvalid [2];
  logic        arready [2];
  logic [31:0] araddr  [2];
  logic        rvalid  [2];
  logic        rready  [2];
  logic [31:0] rdata   [2];
  logic [1:0]  rresp   [2];
  logic        ld_en   [2];
  logic [31:0] ld_addr [2];
  logic [31:0] ld_data [2];

  ysyx_23060061_isram_responder #(.LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst),
    .arvalid(arvalid[0]), .arready(arready[0]), .araddr(araddr[0]),
    .rvalid(rvalid[0]), .rready(rready[0]), .rdata(rdata[0]), .rresp(rresp[0]),
    .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0])
  );

  ysyx_23060061_isram_responder #(.LATENCY(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .arvalid(arvalid[1]), .arready(arready[1]), .araddr(araddr[1]),
    .rvalid(rvalid[1]), .rready(rready[1]), .rdata(rdata[1]), .rresp(rresp[1]),
    .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1])
  );

  int checks   = 0;
  int failures = 0;

  // Reference memory: key = instance*DEPTH + word index.
  logic [31:0] mem_m [int];
  logic [31:0] pool [2][$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_range(input logic [31:0] a);
    longint unsigned x;
    x = 64'(a);
    return (x % 4 == 0) && (x >= LBASE) && (x < LBASE + 4 * DEPTH);
  endfunction

  function automatic int key_of(input int k, input logic [31:0] a);
    longint unsigned x;
    x = 64'(a);
    return k * DEPTH + int'((x - LBASE) / 4);
  endfunction

  task automatic ld(input int k, input logic [31:0] a, input logic [31:0] d);
    ld_en[k]   = 1'b1;
    ld_addr[k] = a;
    ld_data[k] = d;
    step();
    ld_en[k] = 1'b0;
    if (in_range(a)) mem_m[key_of(k, a)] = d;
    $display("LOAD  inst%0d addr=%h data=%h kept=%0d", k, a, d, in_range(a));
  endtask

  // One full read transaction. stall = cycles rready is held low while
  // rvalid is up. coll = drive a load to the same word on the acceptance edge
  // (only meaningful for the zero-latency instance, where that edge is also
  // the RESP-entering edge).
  task automatic do_read(input int k, input logic [31:0] a, input int stall,
                         input bit coll, input logic [31:0] cdata);
    int          lat;
    logic [1:0]  er;
    logic [31:0] ed;
    lat = (k == 0) ? 2 : 0;
    if (in_range(a)) begin
      er = 2'b00;
      ed = mem_m[key_of(k, a)];
    end else begin
      er = 2'b10;
      ed = 32'h0;
    end
    check("arready_before_req", 32'(arready[k]), 32'd1);
    arvalid[k] = 1'b1;
    araddr[k]  = a;
    if (coll) begin
      ld_en[k]   = 1'b1;
      ld_addr[k] = a;
      ld_data[k] = cdata;
    end
    step();
    arvalid[k] = 1'b0;
    araddr[k]  = $urandom;
    ld_en[k]   = 1'b0;
    if (coll && in_range(a)) mem_m[key_of(k, a)] = cdata;
    for (int i = 0; i < lat; i++) begin
      check("rvalid_during_wait", 32'(rvalid[k]), 32'd0);
      check("arready_during_wait", 32'(arready[k]), 32'd0);
      step();
    end
    for (int s = 0; s <= stall; s++) begin
      check("rvalid_resp", 32'(rvalid[k]), 32'd1);
      check("rdata_resp", rdata[k], ed);
      check("rresp_resp", 32'(rresp[k]), 32'(er));
      check("arready_resp", 32'(arready[k]), 32'd0);
      if (s == stall) rready[k] = 1'b1;
      step();
    end
    rready[k] = 1'b0;
    check("rvalid_after_hs", 32'(rvalid[k]), 32'd0);
    check("arready_after_hs", 32'(arready[k]), 32'd1);
    $display("READ  inst%0d addr=%h exp_resp=%b exp_data=%h got_resp=%b got_data=%h stall=%0d",
             k, a, er, ed, rresp[k], rdata[k], stall);
  endtask

  task automatic check_idle(input string tag, input int k);
    check({tag, "_rvalid"}, 32'(rvalid[k]), 32'd0);
    check({tag, "_rdata"}, rdata[k], 32'd0);
    check({tag, "_rresp"}, 32'(rresp[k]), 32'd0);
    check({tag, "_arready"}, 32'(arready[k]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      arvalid[k] = 1'b0; araddr[k] = '0; rready[k] = 1'b0;
      ld_en[k] = 1'b0; ld_addr[k] = '0; ld_data[k] = '0;
    end

    // Reset and idle state, with a request offered while reset is held.
    step();
    arvalid[0] = 1'b1; araddr[0] = 32'h8000_0004;
    step();
    arvalid[0] = 1'b0;
    step();
    rst = 1'b0;
    check_idle("reset0", 0);
    check_idle("reset1", 1);
    step();
    check_idle("post_reset0", 0);
    $display("RESET released");

    // Basic read, backpressure, boundaries on the LATENCY=2 instance.
    ld(0, 32'h8000_0004, 32'hDEAD_BEEF);
    do_read(0, 32'h8000_0004, 0, 1'b0, 32'h0);
    do_read(0, 32'h8000_0004, 5, 1'b0, 32'h0);
    ld(0, 32'h8000_0FFC, 32'hCAFE_F00D);
    do_read(0, 32'h8000_0FFC, 1, 1'b0, 32'h0);
    ld(0, 32'h8000_0000, 32'h0123_4567);
    do_read(0, 32'h8000_0000, 0, 1'b0, 32'h0);

    // Error responses.
    do_read(0, 32'h7FFF_FFFC, 0, 1'b0, 32'h0);
    do_read(0, 32'h8000_1000, 2, 1'b0, 32'h0);
    do_read(0, 32'h8000_0002, 0, 1'b0, 32'h0);
    do_read(0, 32'hFFFF_FFFC, 0, 1'b0, 32'h0);

    // Ignored loads must not alias onto real words.
    ld(0, 32'h8000_1000, 32'hBAD0_0001);
    ld(0, 32'h8000_0006, 32'hBAD0_0002);
    ld(0, 32'h7FFF_FFFC, 32'hBAD0_0003);
    do_read(0, 32'h8000_0000, 0, 1'b0, 32'h0);
    do_read(0, 32'h8000_0004, 0, 1'b0, 32'h0);
    do_read(0, 32'h8000_0FFC, 0, 1'b0, 32'h0);

    // Collision and back-to-back on the LATENCY=0 instance.
    ld(1, 32'h8000_0010, 32'h1111_1111);
    do_read(1, 32'h8000_0010, 0, 1'b1, 32'h2222_2222);
    do_read(1, 32'h8000_0010, 0, 1'b0, 32'h0);
    ld(1, 32'h8000_0014, 32'h3333_3333);
    do_read(1, 32'h8000_0014, 0, 1'b0, 32'h0);
    do_read(1, 32'h8000_0010, 0, 1'b0, 32'h0);
    do_read(1, 32'h8000_0003, 0, 1'b0, 32'h0);

    // Reset while in WAIT: no response is owed afterwards.
    arvalid[0] = 1'b1; araddr[0] = 32'h8000_0004;
    step();
    arvalid[0] = 1'b0;
    check("wait_before_rst_arready", 32'(arready[0]), 32'd0);
    #2 rst = 1'b1;
    #1;
    check_idle("rst_in_wait", 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("no_resp_after_rst", 32'(rvalid[0]), 32'd0);
      step();
    end
    do_read(0, 32'h8000_0004, 0, 1'b0, 32'h0);

    // Reset while in RESP: response dropped at once.
    arvalid[0] = 1'b1; araddr[0] = 32'h8000_0004;
    step();
    arvalid[0] = 1'b0;
    step();
    step();
    check("resp_before_rst_rvalid", 32'(rvalid[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_idle("rst_in_resp", 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("no_resp_after_rst2", 32'(rvalid[0]), 32'd0);
      step();
    end
    $display("RESET mid-operation sequences done");

    // Randomized traffic against the model.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        logic [31:0] a;
        a = 32'(LBASE + 4 * $urandom_range(0, DEPTH - 1));
        ld(k, a, $urandom);
        pool[k].push_back(a);
      end
      for (int t = 0; t < 30; t++) begin
        int          sel;
        logic [31:0] a;
        sel = $urandom_range(0, 9);
        if (sel <= 5) begin
          a = pool[k][$urandom_range(0, pool[k].size() - 1)];
        end else if (sel == 6) begin
          a = 32'(LBASE + $urandom_range(0, 4 * DEPTH - 1));
          a[1:0] = 2'($urandom_range(1, 3));
        end else if (sel == 7) begin
          a = $urandom_range(0, 32'h7FFF_FFFF);
        end else if (sel == 8) begin
          a = 32'(LBASE + 4 * DEPTH + 4 * $urandom_range(0, 1000));
        end else begin
          // Ignored out-of-range load, then an in-range load re-targeting a pool word.
          ld(k, 32'(LBASE + 4 * DEPTH + 4 * $urandom_range(0, 100)), $urandom);
          a = pool[k][$urandom_range(0, pool[k].size() - 1)];
          ld(k, a, $urandom);
        end
        do_read(k, a, $urandom_range(0, 3), 1'b0, 32'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
